// File: rtl/reg_write_tracer.sv
// Register-file write tracer: snoops writeback, queues commits in a FIFO and streams
// them as 3-beat HDR/PC/DATA packets. Optional regMask filter under TRACE_REG_FILTER_EN.
module reg_write_tracer #(
   parameter int DEPTH      = 8,
   parameter int DROP_WIDTH = 16
) (
   input  logic                    clock,
   input  logic                    resetN,
   input  logic [31:0]             pcIn,
   input  logic                    regWrite,
   input  logic [4:0]              writeReg,
   input  logic [31:0]             writeData,
`ifdef TRACE_REG_FILTER_EN
   input  logic [31:0]             regMask,
`endif
   output logic                    traceValid,
   input  logic                    traceReady,
   output logic [31:0]             traceData,
   output logic                    traceLast,
   output logic                    overflow,
   output logic [DROP_WIDTH-1:0]   dropCount,
   output logic [$clog2(DEPTH):0]  fifoLevel
);

   localparam int AW = $clog2(DEPTH);
   localparam int EW = 16 + 5 + 32 + 32;

   typedef enum logic [1:0] {IDLE, HDR, PC, DATA} state_t;

   state_t                  state_reg, state_next;
   logic [EW-1:0]           mem [DEPTH];
   logic [AW-1:0]           wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]             level_reg, level_next;
   logic [15:0]             seq_reg;
   logic                    overflow_reg;
   logic [DROP_WIDTH-1:0]   drop_reg;
   logic                    qualify, full, pop, push, drop;
   logic [EW-1:0]           head;
   logic [15:0]             head_seq;
   logic [4:0]              head_reg;
   logic [31:0]             head_pc, head_data;

`ifdef TRACE_REG_FILTER_EN
   assign qualify = regWrite && (writeReg != 5'd0) && regMask[writeReg];
`else
   assign qualify = regWrite && (writeReg != 5'd0);
`endif

   assign full = (level_reg == (AW+1)'(DEPTH));
   assign pop  = (state_reg == DATA) && traceReady;
   // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
   assign push = qualify && (!full || pop);
   assign drop = qualify && full && !pop;

   always_comb begin
      level_next = level_reg;
      if (push && !pop)
         level_next = level_reg + (AW+1)'(1);
      else if (!push && pop)
         level_next = level_reg - (AW+1)'(1);
   end

   // Storage carries no reset; validity is tracked by the pointers and level.
   always_ff @(posedge clock) begin
      if (push)
         mem[wr_ptr_reg] <= {seq_reg, writeReg, pcIn, writeData};
   end

   assign head      = mem[rd_ptr_reg];
   assign head_seq  = head[84:69];
   assign head_reg  = head[68:64];
   assign head_pc   = head[63:32];
   assign head_data = head[31:0];

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_reg    <= IDLE;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         level_reg    <= '0;
         seq_reg      <= '0;
         overflow_reg <= 1'b0;
         drop_reg     <= '0;
      end else begin
         state_reg <= state_next;
         level_reg <= level_next;
         if (push)
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         if (qualify)
            seq_reg <= seq_reg + 16'd1;
         if (drop) begin
            overflow_reg <= 1'b1;
            if (drop_reg != '1)
               drop_reg <= drop_reg + DROP_WIDTH'(1);
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      traceValid = 1'b0;
      traceLast  = 1'b0;
      traceData  = '0;
      case (state_reg)
         IDLE: begin
            if (level_reg != '0)
               state_next = HDR;
         end
         HDR: begin
            traceValid = 1'b1;
            traceData  = {8'hA5, 3'b000, head_reg, head_seq};
            if (traceReady)
               state_next = PC;
         end
         PC: begin
            traceValid = 1'b1;
            traceData  = head_pc;
            if (traceReady)
               state_next = DATA;
         end
         DATA: begin
            traceValid = 1'b1;
            traceLast  = 1'b1;
            traceData  = head_data;
            // Level after this edge's pop (and any coincident push) decides back-to-back.
            if (traceReady)
               state_next = (level_next != '0) ? HDR : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign overflow  = overflow_reg;
   assign dropCount = drop_reg;
   assign fifoLevel = level_reg;

endmodule

// File: tb/tb_reg_write_tracer.sv
// Directed bench for reg_write_tracer: a scoreboard queue of expected beats is filled as
// writes are driven and drained as the DUT presents accepted beats.
module tb_reg_write_tracer;
   localparam int DEPTH = 8;
   localparam int DW    = 16;

   logic          clock = 1'b0;
   logic          resetN = 1'b0;
   logic [31:0]   pcIn = '0;
   logic          regWrite = 1'b0;
   logic [4:0]    writeReg = '0;
   logic [31:0]   writeData = '0;
   logic          traceReady = 1'b0;
   logic          traceValid, traceLast, overflow;
   logic [31:0]   traceData;
   logic [DW-1:0] dropCount;
   logic [3:0]    fifoLevel;
`ifdef TRACE_REG_FILTER_EN
   logic [31:0]   regMask = '1;
`endif

   reg_write_tracer #(.DEPTH(DEPTH), .DROP_WIDTH(DW)) dut (
      .clock(clock), .resetN(resetN), .pcIn(pcIn), .regWrite(regWrite),
      .writeReg(writeReg), .writeData(writeData),
`ifdef TRACE_REG_FILTER_EN
      .regMask(regMask),
`endif
      .traceValid(traceValid), .traceReady(traceReady), .traceData(traceData),
      .traceLast(traceLast), .overflow(overflow), .dropCount(dropCount),
      .fifoLevel(fifoLevel)
   );

   always #5 clock = ~clock;

   int          errors = 0;
   int          checks = 0;
   logic [32:0] exp_q[$];
   int          model_level = 0;
   logic [15:0] model_seq = '0;
   int          model_drops = 0;
   logic        model_ovf = 1'b0;
   bit          stall_pending = 0;
   logic [31:0] held_data = '0;
   logic        held_last = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at the falling edge: inputs are already set for the coming rising edge.
   task automatic monitor();
      logic [32:0] e;
      if (stall_pending) begin
         chk("stall_valid", 64'(traceValid), 64'd1);
         chk("stall_data", 64'(traceData), 64'(held_data));
         chk("stall_last", 64'(traceLast), 64'(held_last));
      end
      stall_pending = 0;
      if (traceValid && traceReady) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_beat observed=%0h expected=none", traceData);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("beat_data", 64'(traceData), 64'(e[31:0]));
            chk("beat_last", 64'(traceLast), 64'(e[32]));
            $display("beat data=%08h last=%0b", traceData, traceLast);
            if (e[32])
               model_level--;
         end
      end else if (traceValid) begin
         stall_pending = 1;
         held_data = traceData;
         held_last = traceLast;
      end
   endtask

   task automatic cycle();
      @(negedge clock);
      chk("fifoLevel", 64'(fifoLevel), 64'(model_level));
      chk("overflow", 64'(overflow), 64'(model_ovf));
      chk("dropCount", 64'(dropCount), 64'(model_drops));
      monitor();
      if (regWrite && writeReg != 5'd0) begin
         if (model_level < DEPTH) begin
            exp_q.push_back({1'b0, 8'hA5, 3'b000, writeReg, model_seq});
            exp_q.push_back({1'b0, pcIn});
            exp_q.push_back({1'b1, writeData});
            model_level++;
         end else begin
            model_ovf = 1'b1;
            if (model_drops < 65535)
               model_drops++;
         end
         model_seq = model_seq + 16'd1;
      end
      @(posedge clock);
      #1;
      regWrite = 1'b0;
   endtask

   task automatic wr(input logic [31:0] pc, input logic [4:0] rg, input logic [31:0] d);
      pcIn = pc;
      writeReg = rg;
      writeData = d;
      regWrite = 1'b1;
      $display("write pc=%08h reg=%0d data=%08h", pc, rg, d);
      cycle();
   endtask

   task automatic rst();
      resetN = 1'b0;
      #1;
      chk("rst_valid", 64'(traceValid), 64'd0);
      chk("rst_last", 64'(traceLast), 64'd0);
      chk("rst_data", 64'(traceData), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      chk("rst_drop", 64'(dropCount), 64'd0);
      chk("rst_level", 64'(fifoLevel), 64'd0);
      exp_q.delete();
      model_level = 0;
      model_seq = '0;
      model_drops = 0;
      model_ovf = 1'b0;
      stall_pending = 0;
      @(posedge clock);
      #1;
      resetN = 1'b1;
      cycle();
   endtask

   task automatic drain(input int budget);
      int n;
      n = 0;
      traceReady = 1'b1;
      while ((exp_q.size() != 0 || model_level != 0) && n < budget) begin
         cycle();
         n++;
      end
      checks++;
      assert (n < budget) else begin
         errors++;
         $error("FAIL drain_timeout observed=%0d pending expected=0", exp_q.size());
      end
      cycle();
      chk("idle_valid", 64'(traceValid), 64'd0);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Single write, ready held high
      rst();
      traceReady = 1'b1;
      wr(32'h0040_0000, 5'd16, 32'h0000_0005);
      drain(20);
      chk("t1_level", 64'(fifoLevel), 64'd0);

      // $zero writes and disabled writes are ignored, seq untouched
      rst();
      traceReady = 1'b1;
      wr(32'h0040_0004, 5'd0, 32'hDEAD_BEEF);
      writeReg = 5'd5;
      writeData = 32'h1234_5678;
      cycle();
      cycle();
      chk("t2_level", 64'(fifoLevel), 64'd0);
      chk("t2_valid", 64'(traceValid), 64'd0);
      wr(32'h0040_0008, 5'd8, 32'h0000_0042);
      drain(20);

      // Overflow: 10 writes into an 8-deep FIFO with the sink stalled
      rst();
      traceReady = 1'b0;
      for (int i = 0; i < 10; i++)
         wr(32'h0000_1000 + 32'(4 * i), 5'(i + 1), 32'hA000_0000 + 32'(i));
      chk("t3_level", 64'(fifoLevel), 64'd8);
      chk("t3_overflow", 64'(overflow), 64'd1);
      chk("t3_drop", 64'(dropCount), 64'd2);
      drain(60);
      chk("t3_overflow_sticky", 64'(overflow), 64'd1);

      // Ready toggling every cycle during a packet
      rst();
      traceReady = 1'b0;
      wr(32'h0000_2000, 5'd7, 32'h0BAD_F00D);
      for (int i = 0; i < 10; i++) begin
         traceReady = ~traceReady;
         cycle();
      end
      drain(20);

      // Push coinciding with the DATA pop while full
      rst();
      traceReady = 1'b0;
      for (int i = 0; i < 8; i++)
         wr(32'h0000_3000 + 32'(4 * i), 5'(i + 9), 32'hB000_0000 + 32'(i));
      traceReady = 1'b1;
      cycle();
      cycle();
      wr(32'h0000_4000, 5'd31, 32'hCAFE_0001);
      chk("t5_level", 64'(fifoLevel), 64'd8);
      chk("t5_drop", 64'(dropCount), 64'd0);
      chk("t5_overflow", 64'(overflow), 64'd0);
      drain(60);

      // Asynchronous reset in the middle of a PC beat
      rst();
      traceReady = 1'b0;
      wr(32'h0000_5000, 5'd4, 32'h0000_00FF);
      cycle();
      traceReady = 1'b1;
      cycle();
      traceReady = 1'b0;
      chk("t6_pc_valid", 64'(traceValid), 64'd1);
      chk("t6_pc_data", 64'(traceData), 64'h0000_5000);
      rst();
      traceReady = 1'b1;
      wr(32'h0000_6000, 5'd3, 32'h0000_0077);
      drain(20);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
